// File: rtl/seat_request_sequencer.sv
// Seat request sequencer: buffers kiosk seat requests in a FIFO, replays each
// one to the seating controller as a setup/write/capture/gap sequence, and
// keeps the minute-of-day Time counter.
module seat_request_sequencer #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned NUM_SEATS     = 30,
    parameter int unsigned TICKS_PER_MIN = 60,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [24:0]              req_student,
    input  logic [4:0]               req_seat,
    input  logic [1:0]               Seat_State,
    output logic [24:0]              Student_No,
    output logic [4:0]               Seat_No,
    output logic                     write,
    output logic [10:0]              Time,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_state,
    output logic [4:0]               rsp_seat,
    output logic                     reject,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned STU_W    = 25;
    localparam int unsigned SEAT_W   = 5;
    localparam int unsigned TIME_W   = 11;
    localparam int unsigned MIN_LAST = 1439;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CW       = PTR_W + 1;
    localparam int unsigned PRE_W    = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam int unsigned CNT_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    typedef struct packed {
        logic [STU_W-1:0]  student;
        logic [SEAT_W-1:0] seat;
    } req_t;

    req_t               mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               ready_q, reject_q;

    logic [PRE_W-1:0]   pre_q;
    logic [TIME_W-1:0]  time_q;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STU_W-1:0]   student_q, student_d;
    logic [SEAT_W-1:0]  seat_q, seat_d;
    logic               write_q, write_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [1:0]         rsp_state_q, rsp_state_d;
    logic [SEAT_W-1:0]  rsp_seat_q, rsp_seat_d;

    logic               push_c, seat_ok_c, store_c, pop_c;
    req_t               head_c;

    assign push_c    = req_valid && ready_q;
    assign seat_ok_c = (req_seat != '0) && (req_seat <= SEAT_W'(NUM_SEATS));
    assign store_c   = push_c && seat_ok_c;
    assign pop_c     = (state_q == S_IDLE) && (count_q != '0);
    assign head_c    = mem[rd_ptr_q];

    // Occupancy after this cycle's store/pop
    always_comb begin
        count_d = count_q;
        case ({store_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset, the pointers gate validity
    always_ff @(posedge clk) begin
        if (store_c) begin
            mem[wr_ptr_q] <= '{student: req_student, seat: req_seat};
        end
    end

    // FIFO pointers, occupancy, ready and reject pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            reject_q <= 1'b0;
        end else begin
            if (store_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q  <= count_d;
            ready_q  <= (count_d != CW'(DEPTH));
            reject_q <= push_c && !seat_ok_c;
        end
    end

    // Minute prescaler and minute-of-day counter, independent of the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            time_q <= '0;
        end else if (pre_q == PRE_W'(TICKS_PER_MIN - 1)) begin
            pre_q  <= '0;
            time_q <= (time_q == TIME_W'(MIN_LAST)) ? '0 : time_q + TIME_W'(1);
        end else begin
            pre_q  <= pre_q + PRE_W'(1);
        end
    end

    // Sequencer state and registered controller-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            student_q   <= '0;
            seat_q      <= '0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_state_q <= '0;
            rsp_seat_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            student_q   <= student_d;
            seat_q      <= seat_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_state_q <= rsp_state_d;
            rsp_seat_q  <= rsp_seat_d;
        end
    end

    // Next-state and output decode; write follows the next state so it is high exactly in WRITE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        student_d   = student_q;
        seat_d      = seat_q;
        write_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_state_d = rsp_state_q;
        rsp_seat_d  = rsp_seat_q;
        case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    student_d = head_c.student;
                    seat_d    = head_c.seat;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_state_d = Seat_State;
                rsp_seat_d  = seat_q;
                cnt_d       = '0;
                state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        write_d = (state_d == S_WRITE);
    end

    assign req_ready  = ready_q;
    assign reject     = reject_q;
    assign fifo_count = count_q;
    assign Time       = time_q;
    assign Student_No = student_q;
    assign Seat_No    = seat_q;
    assign write      = write_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_state  = rsp_state_q;
    assign rsp_seat   = rsp_seat_q;

endmodule

// File: tb/tb_seat_request_sequencer.sv
// Directed bench for seat_request_sequencer: default-parameter instance plus a
// fast-clock instance (one tick per minute) for the Time wrap.
module tb_seat_request_sequencer;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready;
    logic [24:0] req_student, Student_No;
    logic [4:0]  req_seat, Seat_No, rsp_seat;
    logic [1:0]  Seat_State, rsp_state;
    logic        write, rsp_valid, reject;
    logic [10:0] Time;
    logic [2:0]  fifo_count;

    logic        b_req_valid, b_req_ready;
    logic [24:0] b_req_student, b_Student_No;
    logic [4:0]  b_req_seat, b_Seat_No, b_rsp_seat;
    logic [1:0]  b_Seat_State, b_rsp_state;
    logic        b_write, b_rsp_valid, b_reject;
    logic [10:0] b_Time;
    logic [2:0]  b_fifo_count;

    seat_request_sequencer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_student(req_student), .req_seat(req_seat), .Seat_State(Seat_State),
        .Student_No(Student_No), .Seat_No(Seat_No), .write(write), .Time(Time),
        .rsp_valid(rsp_valid), .rsp_state(rsp_state), .rsp_seat(rsp_seat),
        .reject(reject), .fifo_count(fifo_count)
    );

    seat_request_sequencer #(.TICKS_PER_MIN(1)) dut_fast (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_student(b_req_student), .req_seat(b_req_seat), .Seat_State(b_Seat_State),
        .Student_No(b_Student_No), .Seat_No(b_Seat_No), .write(b_write), .Time(b_Time),
        .rsp_valid(b_rsp_valid), .rsp_state(b_rsp_state), .rsp_seat(b_rsp_seat),
        .reject(b_reject), .fifo_count(b_fifo_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Write-strobe monitor: records seat and cycle of every rising edge of write
    int   wr_n = 0;
    int   wr_seat [64];
    int   wr_cyc  [64];
    logic write_prev = 1'b0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (write && !write_prev && wr_n < 64) begin
            wr_seat[wr_n] = int'(Seat_No);
            wr_cyc[wr_n]  = cyc;
            wr_n = wr_n + 1;
        end
        write_prev = write;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic bad;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
        tests++; if (write !== 1'b0) begin fails++; $display("FAIL reset_write: got %0b want 0", write); end
        tests++; if (Student_No !== 25'd0 || Seat_No !== 5'd0) begin fails++; $display("FAIL reset_data: got %0h/%0d want 0/0", Student_No, Seat_No); end
        tests++; if (Time !== 11'd0) begin fails++; $display("FAIL reset_time: got %0d want 0", Time); end
        tests++; if (rsp_valid !== 1'b0 || rsp_state !== 2'd0 || rsp_seat !== 5'd0) begin fails++; $display("FAIL reset_rsp: got %0b/%0d/%0d want 0/0/0", rsp_valid, rsp_state, rsp_seat); end
        tests++; if (reject !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL reset_fifo: got rej %0b cnt %0d want 0/0", reject, fifo_count); end
        bad = 1'b0;
        repeat (59) begin
            step();
            if (write !== 1'b0 || rsp_valid !== 1'b0 || reject !== 1'b0 || fifo_count !== 3'd0 || Time !== 11'd0)
                bad = 1'b1;
        end
        tests++; if (bad !== 1'b0) begin fails++; $display("FAIL idle_quiet: got activity %0b want 0", bad); end
        tests++; if (Time !== 11'd0) begin fails++; $display("FAIL time_59: got %0d want 0", Time); end
        step();
        tests++; if (Time !== 11'd1) begin fails++; $display("FAIL time_60: got %0d want 1", Time); end
    endtask

    task automatic test_single();
        Seat_State  = 2'b11;
        req_valid   = 1'b1;
        req_student = 25'h1F60873;
        req_seat    = 5'd2;
        step();
        req_valid = 1'b0;
        tests++; if (fifo_count !== 3'd1 || write !== 1'b0) begin fails++; $display("FAIL single_push: got cnt %0d wr %0b want 1/0", fifo_count, write); end
        step();
        tests++; if (write !== 1'b0) begin fails++; $display("FAIL single_setup_write: got %0b want 0", write); end
        tests++; if (Seat_No !== 5'd2 || Student_No !== 25'h1F60873) begin fails++; $display("FAIL single_load: got %0h/%0d want 1f60873/2", Student_No, Seat_No); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL single_pop: got %0d want 0", fifo_count); end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (write !== 1'b1 || Seat_No !== 5'd2) begin fails++; $display("FAIL single_hold%0d: got wr %0b seat %0d want 1/2", i, write, Seat_No); end
        end
        step();
        tests++; if (write !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL single_capture: got wr %0b rv %0b want 0/0", write, rsp_valid); end
        step();
        tests++; if (rsp_valid !== 1'b1 || rsp_state !== 2'd3 || rsp_seat !== 5'd2) begin fails++; $display("FAIL single_rsp: got %0b/%0d/%0d want 1/3/2", rsp_valid, rsp_state, rsp_seat); end
        step();
        tests++; if (rsp_valid !== 1'b0 || Seat_No !== 5'd2) begin fails++; $display("FAIL single_rsp_pulse: got rv %0b seat %0d want 0/2", rsp_valid, Seat_No); end
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        int   start_n, stall, guard, g;
        logic hs, saw_full;
        start_n  = wr_n;
        stall    = 0;
        saw_full = 1'b0;
        Seat_State = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            req_valid   = 1'b1;
            req_seat    = 5'(k);
            req_student = 25'(k * 1000);
            guard = 0;
            do begin
                hs = req_ready;
                step();
                if (fifo_count == 3'(DEPTH)) begin
                    saw_full = 1'b1;
                    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready: got %0b want 0", req_ready); end
                end
                if (!hs) stall++;
                guard++;
            end while (!hs && guard < 50);
            if (!hs) begin
                tests++; fails++; $display("FAIL b2b_push_timeout: seat %0d got no ready want ready", k);
            end
        end
        req_valid = 1'b0;
        tests++; if (saw_full !== 1'b1) begin fails++; $display("FAIL b2b_saw_full: got %0b want 1", saw_full); end
        tests++; if (stall == 0) begin fails++; $display("FAIL b2b_stall: got %0d stall cycles want >0", stall); end
        g = 0;
        while (wr_n - start_n < 6 && g < 100) begin step(); g++; end
        tests++; if (wr_n - start_n !== 6) begin fails++; $display("FAIL b2b_count: got %0d writes want 6", wr_n - start_n); end
        for (int i = 0; i < 6; i++) begin
            if (start_n + i < wr_n) begin
                tests++; if (wr_seat[start_n + i] !== i + 1) begin fails++; $display("FAIL b2b_order%0d: got seat %0d want %0d", i, wr_seat[start_n + i], i + 1); end
                if (i > 0) begin
                    tests++; if (wr_cyc[start_n + i] - wr_cyc[start_n + i - 1] !== 9) begin fails++; $display("FAIL b2b_space%0d: got %0d want 9", i, wr_cyc[start_n + i] - wr_cyc[start_n + i - 1]); end
                end
            end
        end
        repeat (12) step();
        tests++; if (fifo_count !== 3'd0 || wr_n - start_n !== 6) begin fails++; $display("FAIL b2b_drain: got cnt %0d writes %0d want 0/6", fifo_count, wr_n - start_n); end
    endtask

    task automatic test_reject();
        int start_n;
        start_n     = wr_n;
        req_valid   = 1'b1;
        req_student = 25'h0000123;
        req_seat    = 5'd0;
        step();
        req_seat = 5'd31;
        tests++; if (reject !== 1'b1 || fifo_count !== 3'd0) begin fails++; $display("FAIL reject_seat0: got rej %0b cnt %0d want 1/0", reject, fifo_count); end
        step();
        req_valid = 1'b0;
        tests++; if (reject !== 1'b1 || fifo_count !== 3'd0 || req_ready !== 1'b1) begin fails++; $display("FAIL reject_seat31: got rej %0b cnt %0d rdy %0b want 1/0/1", reject, fifo_count, req_ready); end
        step();
        tests++; if (reject !== 1'b0) begin fails++; $display("FAIL reject_pulse: got %0b want 0", reject); end
        repeat (12) step();
        tests++; if (wr_n !== start_n || write !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL reject_nowrite: got writes %0d cnt %0d want 0/0", wr_n - start_n, fifo_count); end
    endtask

    task automatic test_time_wrap();
        int g;
        g = 0;
        while (b_Time !== 11'd1436 && g < 2000) begin step(); g++; end
        tests++; if (b_Time !== 11'd1436) begin fails++; $display("FAIL wrap_reach: got %0d want 1436", b_Time); end
        b_Seat_State  = 2'b01;
        b_req_valid   = 1'b1;
        b_req_seat    = 5'd7;
        b_req_student = 25'h0ABCDE;
        step();
        b_req_valid = 1'b0;
        step(); step();
        tests++; if (b_Time !== 11'd1439 || b_write !== 1'b1 || b_Seat_No !== 5'd7) begin fails++; $display("FAIL wrap_1439: got t %0d wr %0b seat %0d want 1439/1/7", b_Time, b_write, b_Seat_No); end
        step();
        tests++; if (b_Time !== 11'd0 || b_write !== 1'b1) begin fails++; $display("FAIL wrap_zero: got t %0d wr %0b want 0/1", b_Time, b_write); end
        step();
        tests++; if (b_Time !== 11'd1 || b_write !== 1'b1) begin fails++; $display("FAIL wrap_one: got t %0d wr %0b want 1/1", b_Time, b_write); end
        step();
        tests++; if (b_write !== 1'b1 || b_Seat_No !== 5'd7) begin fails++; $display("FAIL wrap_hold4: got wr %0b seat %0d want 1/7", b_write, b_Seat_No); end
        step();
        tests++; if (b_write !== 1'b0) begin fails++; $display("FAIL wrap_end: got %0b want 0", b_write); end
        step();
        tests++; if (b_rsp_valid !== 1'b1 || b_rsp_state !== 2'd1 || b_rsp_seat !== 5'd7) begin fails++; $display("FAIL wrap_rsp: got %0b/%0d/%0d want 1/1/7", b_rsp_valid, b_rsp_state, b_rsp_seat); end
    endtask

    task automatic test_reset_mid();
        int base;
        req_valid   = 1'b1;
        req_student = 25'h0000AAA;
        req_seat    = 5'd3;
        step();
        req_seat = 5'd4;
        step();
        req_seat = 5'd5;
        step();
        req_valid = 1'b0;
        tests++; if (write !== 1'b1 || fifo_count !== 3'd2) begin fails++; $display("FAIL mid_pre: got wr %0b cnt %0d want 1/2", write, fifo_count); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (write !== 1'b0) begin fails++; $display("FAIL mid_async_write: got %0b want 0", write); end
        tests++; if (fifo_count !== 3'd0 || Time !== 11'd0 || req_ready !== 1'b1) begin fails++; $display("FAIL mid_async_state: got cnt %0d t %0d rdy %0b want 0/0/1", fifo_count, Time, req_ready); end
        step(); step();
        reset = 1'b0;
        base = wr_n;
        tests++; if (Time !== 11'd0) begin fails++; $display("FAIL mid_time: got %0d want 0", Time); end
        repeat (30) step();
        tests++; if (wr_n !== base || write !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL mid_after: got writes %0d cnt %0d want 0/0", wr_n - base, fifo_count); end
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_student   = '0;
        req_seat      = '0;
        Seat_State    = '0;
        b_req_valid   = 1'b0;
        b_req_student = '0;
        b_req_seat    = '0;
        b_Seat_State  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_reject();
        test_time_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
